interval_timer_ctrl: RTL and testbench

//  Sequencer for one 4-bit loadable up-counter (sync reset, load > enable priority,
//  c_out = (count==14) & enable & !load). Loads a latched preset, enables counting

---
 rtl/interval_timer_ctrl_if.sv | 40 ++++
 rtl/interval_timer_ctrl.sv | 106 ++++++++++
 tb/tb_interval_timer_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/interval_timer_ctrl_if.sv
// Bundle of host-side and counter-side signals around the interval timer sequencer.
//
// Handshake: there is no valid/ready pair here. `start` is a level request that
// the sequencer accepts only while idle (and only if `abort` is low in the same
// cycle); it is ignored everywhere else. `abort` and `pause` are levels sampled
// every cycle. `done` is a single-cycle completion pulse and `busy` is high while
// a sequence is in progress (LOAD/RUN).
// dbg_state encoding: 0 = IDLE, 1 = LOAD, 2 = RUN, 3 = DONE.
interface interval_timer_ctrl_if #(
    parameter int REP_W = 4
);
    // host side
    logic             start;
    logic             abort;
    logic             pause;
    logic [3:0]       preset;
    logic [REP_W-1:0] reps;
    logic             busy;
    logic             done;
    logic [REP_W-1:0] rep_idx;
    // counter side
    logic             cnt_c_out;
    logic             cnt_load;
    logic             cnt_enable;
    logic [3:0]       cnt_load_val;
    // observability
    logic [1:0]       dbg_state;

    // the sequencer
    modport slave (
        input  start, abort, pause, preset, reps, cnt_c_out,
        output busy, done, rep_idx, cnt_load, cnt_enable, cnt_load_val, dbg_state
    );

    // the host / environment driving the sequencer
    modport master (
        output start, abort, pause, preset, reps, cnt_c_out,
        input  busy, done, rep_idx, cnt_load, cnt_enable, cnt_load_val, dbg_state
    );
endinterface

// File: rtl/interval_timer_ctrl.sv
// Interval timer sequencer: loads a latched preset into an external 4-bit
// up-counter, enables it until its terminal carry, and repeats for a latched
// number of intervals. Reports busy, a one-cycle done pulse and the number of
// intervals completed so far.
module interval_timer_ctrl #(
    parameter int REP_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,   // asynchronous, active-low
    interval_timer_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       preset_q, preset_d;
    logic [REP_W-1:0] reps_q, reps_d;
    logic [REP_W-1:0] rep_idx_q, rep_idx_d;
    logic [REP_W-1:0] rep_next;
    logic             accept_start;
    logic             interval_end;

    // count of intervals including the one finishing now
    assign rep_next     = rep_idx_q + {{(REP_W-1){1'b0}}, 1'b1};
    assign accept_start = (state_q == S_IDLE) && bus.start && !bus.abort;
    // counter carry only matters while counting; abort wins over it
    assign interval_end = (state_q == S_RUN) && bus.cnt_c_out && !bus.abort;

    // state and latched sequence parameters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            preset_q  <= '0;
            reps_q    <= '0;
            rep_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            preset_q  <= preset_d;
            reps_q    <= reps_d;
            rep_idx_q <= rep_idx_d;
        end
    end

    // next-state decision; abort overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.start) state_d = S_LOAD;
            S_LOAD: state_d = S_RUN;
            S_RUN: begin
                if (bus.cnt_c_out) begin
                    state_d = (rep_next == reps_q) ? S_DONE : S_LOAD;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.abort) begin
            state_d = S_IDLE;
        end
    end

    // latch preset/reps on accepted start (0 reps means one interval) and
    // advance the interval index at each terminal carry; held otherwise
    always_comb begin
        preset_d  = preset_q;
        reps_d    = reps_q;
        rep_idx_d = rep_idx_q;
        if (accept_start) begin
            preset_d  = bus.preset;
            reps_d    = (bus.reps == '0) ? {{(REP_W-1){1'b0}}, 1'b1} : bus.reps;
            rep_idx_d = '0;
        end else if (interval_end) begin
            rep_idx_d = rep_next;
        end
    end

    // Moore output decode from the registered state (pause only gates enable)
    always_comb begin
        bus.cnt_load     = 1'b0;
        bus.cnt_enable   = 1'b0;
        bus.busy         = 1'b0;
        bus.done         = 1'b0;
        bus.cnt_load_val = preset_q;
        bus.rep_idx      = rep_idx_q;
        bus.dbg_state    = state_q;
        case (state_q)
            S_LOAD: begin
                bus.cnt_load = 1'b1;
                bus.busy     = 1'b1;
            end
            S_RUN: begin
                bus.cnt_enable = !bus.pause;
                bus.busy       = 1'b1;
            end
            S_DONE: bus.done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Directed bench for interval_timer_ctrl with a behavioural 4-bit counter
// (sync reset, load > enable, c_out = count==14 & enable & !load) closing
// the loop. Cycle k=1 is the first cycle after the edge that accepts start.
module tb_interval_timer_ctrl;

    localparam int REP_W = 4;

    logic clk;
    logic reset;

    interval_timer_ctrl_if #(.REP_W(REP_W)) bus ();

    interval_timer_ctrl #(.REP_W(REP_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // counter datapath model
    logic [3:0] cnt_q;
    always_ff @(posedge clk) begin
        if (!reset)              cnt_q <= 4'd0;
        else if (bus.cnt_load)   cnt_q <= bus.cnt_load_val;
        else if (bus.cnt_enable) cnt_q <= cnt_q + 4'd1;
    end
    assign bus.cnt_c_out = (cnt_q == 4'd14) && bus.cnt_enable && !bus.cnt_load;

    // scoreboard counters
    int n_cmp;
    int n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // per-sequence observations
    int n_load, n_en, n_busy, n_done, done_at, n_paused, lv_bad, busy_run, busy_max;
    int rep_idx_k1;

    // Issue a start with preset p / reps r, then observe ncyc cycles.
    // pause during k in [pz_lo,pz_hi] and also at k==1 if pz_load;
    // abort at k==ab_at; a second start with a different preset at k==st_at.
    task automatic run_seq(input logic [3:0] p, input logic [3:0] r, input int ncyc,
                           input bit pz_load, input int pz_lo, input int pz_hi,
                           input int ab_at, input int st_at);
        n_load = 0; n_en = 0; n_busy = 0; n_done = 0; done_at = 0;
        n_paused = 0; lv_bad = 0; busy_run = 0; busy_max = 0; rep_idx_k1 = -1;
        bus.preset = p;
        bus.reps   = r;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            bus.pause = ((k >= pz_lo) && (k <= pz_hi)) || (pz_load && (k == 1));
            bus.abort = (k == ab_at);
            bus.start = (k == st_at);
            if (k == st_at) bus.preset = p + 4'd3;
            #1;
            if (k == 1) rep_idx_k1 = int'(bus.rep_idx);
            if (bus.cnt_load) n_load++;
            if (bus.cnt_enable) n_en++;
            if (bus.busy && !bus.cnt_load && !bus.cnt_enable) n_paused++;
            if (bus.busy && (bus.cnt_load_val != p)) lv_bad++;
            if (bus.busy) begin
                n_busy++;
                busy_run++;
                if (busy_run > busy_max) busy_max = busy_run;
            end else begin
                busy_run = 0;
            end
            if (bus.done) begin
                n_done++;
                done_at = k;
            end
            tick();
        end
        bus.pause = 1'b0;
        bus.abort = 1'b0;
        bus.start = 1'b0;
        #1;
    endtask

    // compare one sequence's observations against hand-computed values
    task automatic check_seq(input string tag, input int e_load, input int e_en,
                             input int e_busy, input int e_done, input int e_done_at,
                             input int e_rep);
        check({tag, " loads"},     n_load,        e_load);
        check({tag, " enables"},   n_en,          e_en);
        check({tag, " busy_cyc"},  n_busy,        e_busy);
        check({tag, " busy_run"},  busy_max,      e_busy);
        check({tag, " done_cnt"},  n_done,        e_done);
        check({tag, " done_at"},   done_at,       e_done_at);
        check({tag, " rep_idx"},   bus.rep_idx,   e_rep);
        check({tag, " rep_k1"},    rep_idx_k1,    0);
        check({tag, " load_val"},  lv_bad,        0);
        check({tag, " end_state"}, bus.dbg_state, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.pause = 1'b0;
        bus.preset = 4'd0; bus.reps = '0;
        repeat (3) tick();

        // reset state
        check("rst busy",    bus.busy, 0);
        check("rst done",    bus.done, 0);
        check("rst load",    bus.cnt_load, 0);
        check("rst enable",  bus.cnt_enable, 0);
        check("rst loadval", bus.cnt_load_val, 0);
        check("rst rep_idx", bus.rep_idx, 0);
        check("rst state",   bus.dbg_state, 0);
        reset = 1'b1;
        repeat (2) tick();

        // preset 10: RUN 5 cycles (10..14), done at k = 1*(1+5)+1 = 7
        run_seq(4'd10, 4'd1, 10, 1'b0, 0, -1, 0, 0);
        check_seq("p10r1", 1, 5, 6, 1, 7, 1);

        // preset 12 x3: RUN 3 per interval, done at 3*4+1 = 13, busy 12
        run_seq(4'd12, 4'd3, 16, 1'b0, 0, -1, 0, 0);
        check_seq("p12r3", 3, 9, 12, 1, 13, 3);

        // reps 0 behaves as 1; preset 14 gives a single RUN cycle
        run_seq(4'd14, 4'd0, 6, 1'b0, 0, -1, 0, 0);
        check_seq("p14r0", 1, 1, 2, 1, 3, 1);

        // preset 15 wraps: 16 RUN cycles, done at 18
        run_seq(4'd15, 4'd1, 21, 1'b0, 0, -1, 0, 0);
        check_seq("p15r1", 1, 16, 17, 1, 18, 1);

        // maximum reps: 15 intervals of 2 cycles, done at 31
        run_seq(4'd14, 4'd15, 34, 1'b0, 0, -1, 0, 0);
        check_seq("p14r15", 15, 15, 30, 1, 31, 15);

        // pause in LOAD (ignored) and 4 cycles mid-RUN: done 4 cycles later
        run_seq(4'd10, 4'd1, 14, 1'b1, 3, 6, 0, 0);
        check_seq("pause", 1, 5, 10, 1, 11, 1);
        check("pause frozen", n_paused, 4);

        // abort in 3rd interval's RUN (k=10), stray start at k=3
        run_seq(4'd12, 4'd4, 14, 1'b0, 0, -1, 10, 3);
        check("abort loads",    n_load, 3);
        check("abort enables",  n_en, 7);
        check("abort busy",     n_busy, 10);
        check("abort done",     n_done, 0);
        check("abort rep_idx",  bus.rep_idx, 2);
        check("abort state",    bus.dbg_state, 0);
        check("abort load_val", lv_bad, 0);

        // start together with abort in IDLE is not accepted
        bus.preset = 4'd5; bus.reps = 4'd1;
        bus.start = 1'b1; bus.abort = 1'b1;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        #1;
        check("st+ab state",   bus.dbg_state, 0);
        check("st+ab busy",    bus.busy, 0);
        check("st+ab rep_idx", bus.rep_idx, 2);

        // asynchronous reset in the middle of RUN
        bus.preset = 4'd10; bus.reps = 4'd1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        check("mid run enable", bus.cnt_enable, 1);
        reset = 1'b0;
        #1;
        check("arst enable",  bus.cnt_enable, 0);
        check("arst load",    bus.cnt_load, 0);
        check("arst busy",    bus.busy, 0);
        check("arst done",    bus.done, 0);
        check("arst state",   bus.dbg_state, 0);
        tick();
        reset = 1'b1;
        repeat (2) tick();
        check("post rst state", bus.dbg_state, 0);
        check("post rst busy",  bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // hard bound on the whole run
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
